mc_control_fsm: RTL

Multicycle MIPS main control state machine. It sits directly upstream of the ALU decoder: it sequences each instruction through fetch, decode, execute, memory and writeback, and drives the 2-bit aluop consumed by the ALU decoder. It also drives every datapath enable and mux select of the multicycle datapath. Moore machine: all outputs depend on current state only.

---
 rtl/mc_control_fsm.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control state machine
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;

  // Control word for a given state; unlisted fields and illegal codes stay 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:  begin c.alusrcb = 2'b11; end
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   begin c.iord = 1'b1; end
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  begin c.regwrite = 1'b1; end
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; op only matters in DECODE and MEMADR.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // State and control word registered together so outputs track the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= decode(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next);
    end
  end

  assign pcwrite  = r_ctrl.pcwrite;
  assign branch   = r_ctrl.branch;
  assign memwrite = r_ctrl.memwrite;
  assign irwrite  = r_ctrl.irwrite;
  assign regwrite = r_ctrl.regwrite;
  assign iord     = r_ctrl.iord;
  assign alusrca  = r_ctrl.alusrca;
  assign alusrcb  = r_ctrl.alusrcb;
  assign pcsrc    = r_ctrl.pcsrc;
  assign memtoreg = r_ctrl.memtoreg;
  assign regdst   = r_ctrl.regdst;
  assign aluop    = r_ctrl.aluop;
  assign state    = r_state;

endmodule
